// File: rtl/ic1500_mon_pkg.sv
// Shared types and defaults for the ic1500 downstream monitor.
package ic1500_mon_pkg;

    localparam int unsigned DEFAULT_COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        HIT  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/ic1500_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ic1500_monitor.sv
// Observer for ic1500: overlapping 1,0,1 detector on y with saturating hit count.
// Define IC1500_MON_ERRCHK_EN to build the y == q0^q1 consistency checker.
module ic1500_monitor
    import ic1500_mon_pkg::*;
#(
    parameter int unsigned COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic               q0,
    input  logic               q1,
    input  logic               y,
    output logic               det,
    output logic [COUNT_W-1:0] det_count,
    output logic [COUNT_W-1:0] err_count,
    output logic               err_flag
);

    mon_state_e state_q;
    mon_state_e state_d;
    mon_state_e nxt_state;
    logic       det_inc;

    always_comb begin
        nxt_state = state_q;
        case (state_q)
            IDLE:    nxt_state = y ? S1  : IDLE;
            S1:      nxt_state = y ? S1  : S10;
            S10:     nxt_state = y ? HIT : IDLE;
            HIT:     nxt_state = y ? S1  : S10;
            default: nxt_state = IDLE;
        endcase

        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else if (en) begin
            state_d = nxt_state;
        end

        det_inc = en && !clr && (nxt_state == HIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign det = (state_q == HIT);

    sat_counter #(.WIDTH(COUNT_W)) u_det_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (det_inc),
        .count (det_count)
    );

`ifdef IC1500_MON_ERRCHK_EN
    logic mismatch;
    logic err_inc;
    logic err_flag_q;
    logic err_flag_d;

    always_comb begin
        mismatch   = (y != (q0 ^ q1));
        err_inc    = en && !clr && mismatch;
        err_flag_d = err_flag_q;
        if (clr) begin
            err_flag_d = 1'b0;
        end else if (err_inc) begin
            err_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q <= 1'b0;
        end else begin
            err_flag_q <= err_flag_d;
        end
    end

    sat_counter #(.WIDTH(COUNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (err_inc),
        .count (err_count)
    );

    assign err_flag = err_flag_q;
`else
    // Checker removed: q0/q1 are kept as ports but intentionally unused.
    logic unused_chk_inputs;
    assign unused_chk_inputs = q0 ^ q1;
    assign err_count = '0;
    assign err_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_ic1500_monitor.sv
// Directed bench for ic1500_monitor: default width plus a COUNT_W=2 instance sharing stimulus.
module tb_ic1500_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       q0;
    logic       q1;
    logic       y;
    logic       det;
    logic [7:0] det_count;
    logic [7:0] err_count;
    logic       err_flag;
    logic       det2;
    logic [1:0] det_count2;
    logic [1:0] err_count2;
    logic       err_flag2;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

`ifdef IC1500_MON_ERRCHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    ic1500_monitor u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q0(q0), .q1(q1), .y(y),
        .det(det), .det_count(det_count), .err_count(err_count), .err_flag(err_flag)
    );

    ic1500_monitor #(.COUNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .q0(q0), .q1(q1), .y(y),
        .det(det2), .det_count(det_count2), .err_count(err_count2), .err_flag(err_flag2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One enabled-or-not clock with explicit q0/q1; inputs change on the falling edge.
    task automatic cycq(input logic yv, input logic q0v, input logic q1v, input logic ev);
        @(negedge clk);
        y = yv; q0 = q0v; q1 = q1v; en = ev; clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic yv, input logic ev);
        cycq(yv, yv, 1'b0, ev);
    endtask

    task automatic do_clr();
        @(negedge clk);
        y = 1'b1; q0 = 1'b0; q1 = 1'b0; en = 1'b1; clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; q0 = 1'b0; q1 = 1'b0; y = 1'b0;
        #12;
        chk("rst_det",      {15'd0, det},       16'd0);
        chk("rst_det_count", {8'd0, det_count}, 16'd0);
        chk("rst_err_count", {8'd0, err_count}, 16'd0);
        chk("rst_err_flag", {15'd0, err_flag},  16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1,0,1 -> single detection
        cyc(1, 1); chk("t1_det_a", {15'd0, det}, 16'd0);
        cyc(0, 1); chk("t1_det_b", {15'd0, det}, 16'd0);
        cyc(1, 1); chk("t1_det_c", {15'd0, det}, 16'd1);
        chk("t1_count", {8'd0, det_count}, 16'd1);
        cyc(0, 1); chk("t1_det_drop", {15'd0, det}, 16'd0);

        // clr discards the sample and zeroes counters
        do_clr();
        chk("clr_count", {8'd0, det_count}, 16'd0);
        chk("clr_det",   {15'd0, det},      16'd0);

        // 1,0,1,0,1 -> overlapping, two pulses
        cyc(1, 1); cyc(0, 1);
        cyc(1, 1); chk("t2_det_1", {15'd0, det}, 16'd1);
        cyc(0, 1); chk("t2_det_gap", {15'd0, det}, 16'd0);
        cyc(1, 1); chk("t2_det_2", {15'd0, det}, 16'd1);
        chk("t2_count", {8'd0, det_count}, 16'd2);

        // enable gap inside the prefix
        do_clr();
        cyc(1, 1); cyc(0, 1);
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        chk("t3_hold_det", {15'd0, det}, 16'd0);
        cyc(1, 1); chk("t3_det", {15'd0, det}, 16'd1);
        chk("t3_count", {8'd0, det_count}, 16'd1);

        // saturation on the 2-bit instance; wide instance keeps counting
        do_clr();
        pulses = 0;
        for (int unsigned k = 1; k <= 5; k++) begin
            cyc(1, 1); cyc(0, 1); cyc(1, 1);
            if (det2) pulses++;
            chk("t4_sat_count", {14'd0, det_count2}, (k > 3) ? 16'd3 : 16'(k));
        end
        chk("t4_pulses", 16'(pulses), 16'd5);
        chk("t4_wide_count", {8'd0, det_count}, 16'd5);

        // consistency checker
        do_clr();
        cycq(0, 1, 0, 1);
        chk("t5_err_count", {8'd0, err_count}, {15'd0, CHK});
        chk("t5_err_flag",  {15'd0, err_flag}, {15'd0, CHK});
        cycq(0, 1, 1, 1);
        chk("t5_flag_sticky", {15'd0, err_flag},  {15'd0, CHK});
        chk("t5_count_hold",  {8'd0, err_count},  {15'd0, CHK});
        cycq(1, 1, 1, 0);
        chk("t5_en_off_hold", {8'd0, err_count},  {15'd0, CHK});
        do_clr();
        chk("t5_clr_err_count", {8'd0, err_count}, 16'd0);
        chk("t5_clr_err_flag",  {15'd0, err_flag}, 16'd0);
        chk("t5_clr_det_count", {8'd0, det_count}, 16'd0);

        // async reset mid-sequence (state left in S10 before reset)
        cyc(1, 1); cyc(0, 1); cyc(1, 1); cyc(0, 1);
        chk("t6_pre_count", {8'd0, det_count}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_count", {8'd0, det_count}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1);
        chk("t6_no_det",   {15'd0, det},      16'd0);
        chk("t6_count",    {8'd0, det_count}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ic1500_monitor.md
# ic1500_monitor

Downstream observer for the dual flip-flop stage `ic1500`. Samples that stage's `q0`, `q1` and `y` outputs every clock and runs a Moore FSM that detects the overlapping bit sequence 1,0,1 on `y`. It counts detections in a saturating counter and, optionally, checks `y == q0 ^ q1` every enabled cycle. It sits in the lab datapath between `ic1500` and the board LEDs/seven-segment driver.

## Interface
- `COUNT_W`, default 8: width of `det_count` and `err_count`; legal range 2..16.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: sample enable; when low, all state holds.
- `clr` input, 1 bit: synchronous clear; has priority over `en`.
- `q0` input, 1 bit: `ic1500` flip-flop 0 output.
- `q1` input, 1 bit: `ic1500` flip-flop 1 output.
- `y` input, 1 bit: `ic1500` combined output; this is the monitored bit stream.
- `det` output, 1 bit: high while the FSM is in HIT.
- `det_count` output, `COUNT_W` bits: number of detections, saturating.
- `err_count` output, `COUNT_W` bits: number of consistency mismatches, saturating.
- `err_flag` output, 1 bit: sticky; set on the first mismatch.

## Operation
- FSM states: IDLE (no useful prefix), S1 (seen 1), S10 (seen 1,0), HIT (seen 1,0,1).
- Transitions, taken on the rising edge with `en=1`, listed as (y=0 / y=1):
  - IDLE: IDLE / S1
  - S1: S10 / S1
  - S10: IDLE / HIT
  - HIT: S10 / S1
- Detection is overlapping: the stream 1,0,1,0,1 produces two detections.
- `det` is a pure Moore output: `det = (state == HIT)`.
- `det_count` increments by 1 on every edge that enters HIT, including HIT→…→HIT through S10.
- `det_count` saturates at 2^COUNT_W−1 and never wraps.
- Checker, when compiled in:
  - On each enabled edge, if `y != (q0 ^ q1)`, `err_count` increments (saturating) and `err_flag` is set.
  - `err_flag` clears only on reset or `clr`.
- `en=0`: state, counters and flag all hold; inputs are ignored.
- `clr=1` on an edge: state→IDLE, counters→0, `err_flag`→0, regardless of `en` and `y`. The sample presented on that edge is discarded.

## Timing
- Reset values: state IDLE, `det`=0, `det_count`=0, `err_count`=0, `err_flag`=0.
- Reset asserts immediately and asynchronously. Reset deassertion mid-sequence restarts detection from IDLE.
- Latency: `det` rises in the cycle after the edge that samples the final 1, and stays high for exactly one cycle unless the FSM re-enters HIT.
- `det_count` updates on the same edge that `det` rises; the new value is visible together with `det`.
- Saturation: an increment at max holds at max. `det` still pulses normally.
- Inputs are assumed stable at the rising edge, since `ic1500` changes its outputs on the same clock. The monitor therefore sees `ic1500` outputs one cycle after they are produced.

## Configuration
- Macro: `IC1500_MON_ERRCHK_EN`.
- Defined: the consistency checker is built; `err_count` and `err_flag` behave as described above.
- Undefined: the checker logic is removed. `err_count` is tied to 0 and `err_flag` to 0; ports remain present.

## Structure
- Package `ic1500_mon_pkg` holds:
  - the state enum: IDLE=2'd0, S1=2'd1, S10=2'd2, HIT=2'd3;
  - the default `COUNT_W` constant.
- Sub-module `sat_counter` (parameter width; inputs `clk`, `rst_n`, `clr`, `inc`; output `count`) is instantiated twice: once for detections, once for errors.

## Test plan
- Reset then y=1,0,1 with `en`=1 → `det`=1 for one cycle after the third edge; `det_count`=1.
- y=1,0,1,0,1 → two `det` pulses two cycles apart; `det_count`=2.
- y=1,0 then `en`=0 for 3 cycles with y=0, then `en`=1 and y=1 → detection occurs; `det_count`=1.
- `COUNT_W`=2, repeat 1,0,1 five times → `det_count` stops at 3; `det` still pulses five times.
- Checker on: q0=1, q1=0, y=0 for one cycle → `err_count`=1, `err_flag`=1; then consistent inputs keep `err_flag`=1; then `clr` → all outputs 0.
- Mid-sequence: y=1,0 then `rst_n`=0 asynchronously, release, y=1 → no detection; `det_count`=0.
